// File: rtl/control_alarma_if.sv
// Bus bundle for the alarm controller: fault inputs, timebase, ack,
// and the registered actuator/status outputs.
interface control_alarma_if #(
  parameter int R = 3
);
  logic         muestra;
  logic [R-1:0] senal_corriente;
  logic         senal_humo;
  logic         tick;
  logic         ack;
  logic         alarma;
  logic         ventilador;
  logic         rele_corte;
  logic [2:0]   estado;

  modport master (
    output muestra, senal_corriente, senal_humo, tick, ack,
    input  alarma, ventilador, rele_corte, estado
  );

  modport slave (
    input  muestra, senal_corriente, senal_humo, tick, ack,
    output alarma, ventilador, rele_corte, estado
  );
endinterface

// File: rtl/control_alarma.sv
// Supervisory alarm FSM: persistence-qualified faults, timed cut-off, ack.
// Optional HUMO_DIRECTO_EN: smoke faults bypass persistence.
module control_alarma #(
  parameter int R       = 3,
  parameter int UMBRAL  = 5,
  parameter int PERSIST = 4,
  parameter int T_CORTE = 8
) (
  input logic              clk,
  input logic              reset,
  control_alarma_if.slave  bus
);
  localparam int CW = $clog2(PERSIST + 1);
  localparam int TW = $clog2(T_CORTE + 1);
  localparam logic [R-1:0]  UMB  = R'(UMBRAL);
  localparam logic [CW-1:0] P_M1 = CW'(PERSIST - 1);
  localparam logic [TW-1:0] T_M1 = TW'(T_CORTE - 1);

  typedef enum logic [2:0] {
    NORMAL     = 3'd0,
    PRE_ALARMA = 3'd1,
    ALARMA     = 3'd2,
    CORTE      = 3'd3,
    RECONOCIDO = 3'd4
  } state_t;

  state_t        st, ns;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tim, tim_n;
  logic          humo_lat, hl_n;
  logic          from_corte, fc_n;
  logic          ack_d;
  logic          ack_pulso;
  logic          falla_cond, falla, limpio;
  logic          humo_dir;

  assign falla_cond = (bus.senal_corriente >= UMB) | bus.senal_humo;
  assign falla      = bus.muestra & falla_cond;
  assign limpio     = bus.muestra & ~falla_cond;
  assign ack_pulso  = bus.ack & ~ack_d;

`ifdef HUMO_DIRECTO_EN
  assign humo_dir = bus.senal_humo;
`else
  assign humo_dir = 1'b0;
`endif

  // Next state, counters, latches; counters clear on every state change
  always_comb begin
    ns    = st;
    cnt_n = cnt;
    tim_n = tim;
    hl_n  = humo_lat;
    fc_n  = from_corte;
    unique case (st)
      NORMAL: begin
        if (falla) begin
          if (PERSIST == 1 || humo_dir) ns = ALARMA;
          else                          ns = PRE_ALARMA;
        end
      end
      PRE_ALARMA: begin
        if (falla) begin
          if (humo_dir || cnt >= P_M1) ns = ALARMA;
          else cnt_n = cnt + CW'(1);
        end else if (limpio) begin
          ns = NORMAL;
        end
      end
      ALARMA: begin
        if (ack_pulso) begin
          ns   = RECONOCIDO;
          fc_n = 1'b0;
        end else if (bus.tick) begin
          if (tim >= T_M1) ns = CORTE;
          else tim_n = tim + TW'(1);
        end
      end
      CORTE: begin
        if (ack_pulso) begin
          ns   = RECONOCIDO;
          fc_n = 1'b1;
        end
      end
      RECONOCIDO: begin
        if (limpio) begin
          if (cnt >= P_M1) ns = NORMAL;
          else cnt_n = cnt + CW'(1);
        end else if (falla) begin
          cnt_n = '0;
        end
      end
      default: ns = NORMAL;
    endcase
    if (falla && bus.senal_humo &&
        (st == PRE_ALARMA || st == ALARMA || st == CORTE))
      hl_n = 1'b1;
    if (ns != st) begin
      tim_n = '0;
      cnt_n = (ns == PRE_ALARMA) ? CW'(1) : '0;
    end
    if (ns == NORMAL) begin
      hl_n = 1'b0;
      fc_n = 1'b0;
    end
  end

  // State, counters and registered outputs share one edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      st             <= NORMAL;
      cnt            <= '0;
      tim            <= '0;
      humo_lat       <= 1'b0;
      from_corte     <= 1'b0;
      ack_d          <= 1'b0;
      bus.alarma     <= 1'b0;
      bus.ventilador <= 1'b0;
      bus.rele_corte <= 1'b0;
      bus.estado     <= 3'd0;
    end else begin
      st             <= ns;
      cnt            <= cnt_n;
      tim            <= tim_n;
      humo_lat       <= hl_n;
      from_corte     <= fc_n;
      ack_d          <= bus.ack;
      bus.alarma     <= (ns == ALARMA) || (ns == CORTE);
      bus.ventilador <= hl_n &&
                        (ns == ALARMA || ns == CORTE || ns == RECONOCIDO);
      bus.rele_corte <= (ns == CORTE) || (ns == RECONOCIDO && fc_n);
      bus.estado     <= ns;
    end
  end
endmodule

// File: tb/tb_control_alarma.sv
// Scoreboard bench for control_alarma: expected outputs queued per
// driven cycle, popped and compared one edge later.
module tb_control_alarma;
`ifdef HUMO_DIRECTO_EN
  localparam bit HD = 1'b1;
`else
  localparam bit HD = 1'b0;
`endif

  typedef struct {
    string tag;
    int    e;
    int    al;
    int    ve;
    int    re;
  } exp_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t x;

  control_alarma_if #(.R(3)) bus ();

  control_alarma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input bit rs, input bit m,
                     input int c, input bit h, input bit tk,
                     input bit ak, input int e, input int al,
                     input int ve, input int re);
    exp_t t;
    @(negedge clk);
    reset               = rs;
    bus.muestra         = m;
    bus.senal_corriente = 3'(c);
    bus.senal_humo      = h;
    bus.tick            = tk;
    bus.ack             = ak;
    t.tag = tag;
    t.e   = e;
    t.al  = al;
    t.ve  = ve;
    t.re  = re;
    sb.push_back(t);
  endtask

  // Compare DUT outputs just after each active edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk({x.tag, ".estado"}, int'(bus.estado), x.e);
      chk({x.tag, ".alarma"}, int'(bus.alarma), x.al);
      chk({x.tag, ".vent"}, int'(bus.ventilador), x.ve);
      chk({x.tag, ".rele"}, int'(bus.rele_corte), x.re);
    end
  end

  initial begin
    reset               = 1'b0;
    bus.muestra         = 1'b0;
    bus.senal_corriente = 3'd0;
    bus.senal_humo      = 1'b0;
    bus.tick            = 1'b0;
    bus.ack             = 1'b0;

    // reset dominates active fault inputs
    cyc("rst0", 0, 1, 7, 1, 0, 0, 0, 0, 0, 0);
    cyc("rst1", 0, 1, 7, 1, 0, 0, 0, 0, 0, 0);
    cyc("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // three overloads then a clear sample
    for (int i = 0; i < 3; i++)
      cyc("pre", 1, 1, 5, 0, 0, 0, 1, 0, 0, 0);
    cyc("back", 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    cyc("nomu", 1, 0, 7, 0, 0, 0, 0, 0, 0, 0);

    // four consecutive overloads raise the alarm
    for (int i = 0; i < 3; i++)
      cyc("pers", 1, 1, 5, 0, 0, 0, 1, 0, 0, 0);
    cyc("alrm", 1, 1, 6, 0, 0, 0, 2, 1, 0, 0);
    cyc("latch", 1, 1, 0, 0, 0, 0, 2, 1, 0, 0);

    // eight ticks to cut-off
    for (int i = 0; i < 7; i++)
      cyc("tick", 1, 0, 0, 0, 1, 0, 2, 1, 0, 0);
    cyc("corte", 1, 0, 0, 0, 1, 0, 3, 1, 0, 1);
    cyc("hold", 1, 0, 0, 0, 0, 0, 3, 1, 0, 1);

    // held ack gives a single event
    cyc("ack", 1, 0, 0, 0, 0, 1, 4, 0, 0, 1);
    for (int i = 0; i < 9; i++)
      cyc("ackh", 1, 0, 0, 0, 0, 1, 4, 0, 0, 1);

    // a fault inside RECONOCIDO restarts the clear count
    cyc("clr", 1, 1, 0, 0, 0, 0, 4, 0, 0, 1);
    cyc("clr", 1, 1, 0, 0, 0, 0, 4, 0, 0, 1);
    cyc("rflt", 1, 1, 5, 0, 0, 0, 4, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      cyc("clr", 1, 1, 0, 0, 0, 0, 4, 0, 0, 1);
    cyc("norm", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // smoke path, fan latched
    for (int i = 1; i <= 4; i++)
      cyc("humo", 1, 1, 0, 1, 0, 0,
          (HD || i == 4) ? 2 : 1,
          (HD || i == 4) ? 1 : 0,
          (HD ? (i >= 2) : (i == 4)) ? 1 : 0, 0);
    for (int i = 0; i < 7; i++)
      cyc("htick", 1, 0, 0, 0, 1, 0, 2, 1, 1, 0);
    cyc("ackwin", 1, 0, 0, 0, 1, 1, 4, 0, 1, 0);
    cyc("hrec", 1, 0, 0, 0, 1, 0, 4, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      cyc("hclr", 1, 1, 0, 0, 0, 0, 4, 0, 1, 0);
    cyc("hnorm", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // ack ignored in NORMAL
    cyc("ackn", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc("ackn0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // single smoke sample: bypass depends on configuration
    cyc("hd", 1, 1, 0, 1, 0, 0, HD ? 2 : 1, HD ? 1 : 0, 0, 0);
    cyc("hd0", 1, 1, 0, 0, 0, 0, HD ? 2 : 0, HD ? 1 : 0, 0, 0);
    cyc("hdr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset while in CORTE drops the relay on that edge
    for (int i = 1; i <= 4; i++)
      cyc("r2", 1, 1, 7, 0, 0, 0, i == 4 ? 2 : 1, i == 4 ? 1 : 0, 0, 0);
    for (int i = 0; i < 7; i++)
      cyc("r2t", 1, 0, 0, 0, 1, 0, 2, 1, 0, 0);
    cyc("r2c", 1, 0, 0, 0, 1, 0, 3, 1, 0, 1);
    cyc("rstc", 0, 1, 7, 1, 1, 0, 0, 0, 0, 0);
    cyc("post", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (4) @(negedge clk);
    if (sb.size() != 0) chk("drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
